spi_register_initiator: RTL and testbench
=========================================

# spi_register_initiator

Fixed-format SPI initiator (master) for the FPGA's 16-bit register-bank link: one transaction is an 8-bit address followed by an 8-bit value, MSB first. The block also captures the responder's readback byte from the second half of the frame. It runs on the system clock and generates the serial clock, chip select and MOSI. It is used for board-level loopback against the register bank and to drive downstream SPI peripherals that use the same frame format.

## Interface
Parameters:
- `DIV`, default 4: half-period of `spi_clk` in `clk` cycles. Legal range 2..255.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  transaction request; sampled only while `busy`=0.
- `addr`  in  8  register address, sent first; latched on accept.
- `wdata`  in  8  value byte, sent second; latched on accept.
- `busy`  out  1  high from the accept cycle through the end of the inter-frame gap.
- `done`  out  1  one-cycle pulse in the cycle `spi_cs` returns high.
- `rdata`  out  8  last 8 MISO bits of the frame, MSB first; updated with `done` and held until the next `done`.
- `spi_clk`  out  1  serial clock; idles low.
- `spi_cs`  out  1  chip select, active low; idles high.
- `spi_mosi`  out  1  serial data out.
- `spi_miso`  in  1  serial data in.

## Operation
- Frame: `tx[15:0] = {addr, wdata}`, shifted MSB first. 16 `spi_clk` pulses per frame, no more, no fewer.
- Responder contract:
  - The responder samples MOSI on the falling edge of `spi_clk`.
  - The responder updates MISO after each falling edge.
  - The responder treats `spi_cs` high as a reset and commits the frame on the rising edge of `spi_cs`.
- The initiator changes MOSI only on the rising edge of `spi_clk`, or when `spi_cs` falls for bit 15.
- The initiator samples `spi_miso` in the cycle it drives `spi_clk` high. MISO has been stable for `DIV` cycles at that point.
- State machine (phase counter `div_cnt` counts 0..DIV-1; the state advances when `div_cnt`=DIV-1):
  - IDLE: `spi_cs`=1, `spi_clk`=0, `busy`=0. On `start`=1, latch `tx`, set `bit_cnt`=15, drive `spi_cs`=0 and `spi_mosi`=`tx[15]`, set `busy`=1, go to SETUP.
  - SETUP: lasts DIV cycles. On exit, drive `spi_clk`=1, shift `spi_miso` into `rx`, go to HIGH.
  - HIGH: lasts DIV cycles. On exit, drive `spi_clk`=0 (the responder samples here), go to LOW.
  - LOW: lasts DIV cycles. On exit:
    - If `bit_cnt`>0: decrement `bit_cnt`, drive `spi_mosi`=`tx[bit_cnt-1]`, drive `spi_clk`=1, sample MISO, go to HIGH.
    - If `bit_cnt`=0: drive `spi_cs`=1, `spi_mosi`=0, load `rdata`=`rx[7:0]`, pulse `done`, go to GAP.
  - GAP: lasts DIV cycles with `spi_cs`=1, then `busy`=0 and go to IDLE.
- `rx` is a 16-bit shift register. Its first 8 samples (the address phase) are discarded.
- `start` while `busy`=1 is ignored and not queued. If `start` is held high, a new frame is accepted in the first cycle `busy` is low.
- `addr`/`wdata` changes after the accept cycle have no effect on the frame in flight.

## Timing
- Reset values (asynchronous, effective immediately, including mid-frame):
  - `spi_cs`=1, `spi_clk`=0, `spi_mosi`=0, `busy`=0, `done`=0, `rdata`=0, state IDLE.
  - A frame aborted by reset is not committed by the responder, because no `done` is issued.
- Accept at edge T: `spi_cs`, `spi_mosi` and `busy` change at edge T.
- First `spi_clk` rise at T+DIV. Rise k (k=0..15) at T+DIV+2·k·DIV; fall k at T+2·DIV+2·k·DIV.
- `spi_cs` rises and `done` pulses at T+33·DIV. `busy` falls at T+34·DIV.
- With DIV=4: `spi_cs` is low for 132 cycles; the accept-to-accept minimum is 136 cycles.
- Every MOSI bit is stable ≥DIV cycles before and after its sampling falling edge.

## Test plan
- Write: DIV=4, addr=0x07, wdata=0x35. Required: MOSI sampled on the 16 falling edges = 0x0735; exactly 16 rises; `spi_cs` low for 132 cycles; one `done` pulse.
- Readback: a responder model drives 0x00A5 MSB-first on MISO, with address 0x07. Required: `rdata`=0xA5 at `done`, held through the next frame start.
- Busy rejection: pulse `start` with addr=0x0B at cycle T+50 of a frame with addr=0x07. Required: only the 0x07 frame occurs; `busy` falls at T+136.
- Back-to-back: `start` held high for 2 frames. Required: second `spi_cs` fall exactly 136 cycles after the first; second frame uses the inputs present at its accept cycle.
- Reset mid-frame: `rst_n`=0 after rise 9. Required: same cycle `spi_cs`=1, `spi_clk`=0, `busy`=0, `rdata`=0; no `done`; the next `start` yields a clean 16-bit frame.
- DIV=2: frame 0xFF00 with MISO tied 1. Required: `rdata`=0xFF; rise spacing 4 cycles; `spi_cs` low for 66 cycles.

Source files
------------

// File: rtl/spi_register_initiator.sv
`default_nettype none
// ============================================================================
// Module      : spi_register_initiator
// Description : Fixed-format SPI initiator for the 16-bit register-bank link.
//               Sends {addr, wdata} MSB first (16 spi_clk pulses, clock idles
//               low) and captures the responder's last 8 MISO bits as rdata.
// Ports       : clk, rst_n            - system clock, async active-low reset
//               start, addr, wdata    - transaction request and payload
//               busy, done, rdata     - status, end-of-frame pulse, readback
//               spi_clk, spi_cs,
//               spi_mosi, spi_miso    - serial link
// Revision    : 1.0 - initial release
// ============================================================================
module spi_register_initiator #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [7:0] c_div_last = 8'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  div_cnt_q;
  logic [3:0]  bit_cnt_q;
  logic [15:0] tx_q;
  // Only the data-phase samples matter: the 8 address-phase samples are
  // simply shifted out of the top of this register by the later ones.
  logic [7:0]  rx_q;
  logic [7:0]  rdata_q;
  logic        busy_q;
  logic        done_q;
  logic        spi_clk_q;
  logic        spi_cs_q;
  logic        spi_mosi_q;

  logic        w_phase_end;
  logic        w_accept;
  logic [3:0]  w_next_bit;

  assign w_phase_end = (div_cnt_q == c_div_last);
  // The last GAP cycle also acts as the first idle sampling cycle, so a held
  // start re-launches exactly 34*DIV cycles after the previous accept.
  assign w_accept    = start && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_GAP) && w_phase_end));
  assign w_next_bit  = bit_cnt_q - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      spi_clk_q  <= 1'b0;
      spi_cs_q   <= 1'b1;
      spi_mosi_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if ((state_q == ST_IDLE) || w_phase_end) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + 8'd1;
      end

      if (w_accept) begin
        tx_q       <= {addr, wdata};
        bit_cnt_q  <= 4'd15;
        spi_cs_q   <= 1'b0;
        spi_mosi_q <= addr[7];
        busy_q     <= 1'b1;
        state_q    <= ST_SETUP;
      end else if (w_phase_end) begin
        case (state_q)
          ST_SETUP: begin
            spi_clk_q <= 1'b1;
            rx_q      <= {rx_q[6:0], spi_miso};
            state_q   <= ST_HIGH;
          end
          ST_HIGH: begin
            spi_clk_q <= 1'b0;
            state_q   <= ST_LOW;
          end
          ST_LOW: begin
            if (bit_cnt_q != 4'd0) begin
              // MOSI moves together with the rising edge, a full half-period
              // away from the responder's falling-edge sample.
              bit_cnt_q  <= w_next_bit;
              spi_mosi_q <= tx_q[w_next_bit];
              spi_clk_q  <= 1'b1;
              rx_q       <= {rx_q[6:0], spi_miso};
              state_q    <= ST_HIGH;
            end else begin
              spi_cs_q   <= 1'b1;
              spi_mosi_q <= 1'b0;
              rdata_q    <= rx_q;
              done_q     <= 1'b1;
              state_q    <= ST_GAP;
            end
          end
          ST_GAP: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_clk  = spi_clk_q;
  assign spi_cs   = spi_cs_q;
  assign spi_mosi = spi_mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_register_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_register_initiator
// Description : Scoreboard bench for spi_register_initiator. Stimulus pushes
//               the expected frame and readback; a monitor acting as the
//               responder pops and compares at each frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_register_initiator;

  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] addr  = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, spi_clk, spi_cs, spi_mosi;
  logic [7:0] rdata;
  logic       spi_miso = 1'b0;

  logic       start2 = 1'b0;
  logic [7:0] addr2  = '0;
  logic [7:0] wdata2 = '0;
  logic       busy2, done2, spi_clk2, spi_cs2, spi_mosi2;
  logic [7:0] rdata2;
  logic       spi_miso2 = 1'b1;

  spi_register_initiator #(.DIV(DIV)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .spi_clk(spi_clk),
    .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_register_initiator #(.DIV(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .addr(addr2), .wdata(wdata2),
    .busy(busy2), .done(done2), .rdata(rdata2), .spi_clk(spi_clk2),
    .spi_cs(spi_cs2), .spi_mosi(spi_mosi2), .spi_miso(spi_miso2)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  longint      cyc     = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard entry: frame on MOSI, word the responder returns, and whether
  // this frame must follow its predecessor back-to-back.
  typedef struct packed {
    logic [15:0] frame;
    logic [15:0] resp;
    logic        b2b;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- monitor + responder model ----------------
  exp_t        cur;
  bit          active = 0;
  int          rises = 0;
  int          bidx = 0;
  bit          spacing_ok = 1;
  logic [15:0] mosi_sh = '0;
  longint      fall_cyc = 0, prev_fall_cyc = 0, last_rise = 0;
  logic [7:0]  model_rdata = '0;
  logic        p_cs = 1'b1, p_clk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active      = 0;
      model_rdata = '0;
      spi_miso    = 1'b0;
      p_cs        = spi_cs;
      p_clk       = spi_clk;
    end else begin
      if (p_cs && !spi_cs) begin
        check("rdata_held", rdata, model_rdata);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_frame: frame started, required none pending");
          active = 0;
        end else begin
          cur        = exp_q.pop_front();
          active     = 1;
          rises      = 0;
          mosi_sh    = '0;
          spacing_ok = 1;
          fall_cyc   = cyc;
          bidx       = 15;
          spi_miso   = cur.resp[15];
          if (cur.b2b) check("b2b_spacing", 32'(cyc - prev_fall_cyc), 34 * DIV);
          prev_fall_cyc = cyc;
        end
      end
      if (active && !p_clk && spi_clk) begin
        if (rises > 0 && (cyc - last_rise) != 2 * DIV) spacing_ok = 0;
        last_rise = cyc;
        rises++;
      end
      if (active && p_clk && !spi_clk) begin
        mosi_sh = {mosi_sh[14:0], spi_mosi};
        bidx--;
        if (bidx >= 0) spi_miso = cur.resp[bidx];
      end
      if (done || (!p_cs && spi_cs)) begin
        check("done_at_cs_rise", done, (!p_cs && spi_cs));
        if (active && !p_cs && spi_cs) begin
          check("rise_count", rises, 16);
          check("rise_spacing", spacing_ok, 1);
          check("cs_low_cycles", 32'(cyc - fall_cyc), 33 * DIV);
          check("mosi_frame", mosi_sh, cur.frame);
          check("rdata", rdata, cur.resp[7:0]);
          model_rdata = cur.resp[7:0];
          active = 0;
        end
      end
      p_cs  = spi_cs;
      p_clk = spi_clk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin @(negedge clk); n++; end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: busy=1, required 0");
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] d, input logic [15:0] r);
    exp_t e;
    wait_idle();
    e.frame = {a, d}; e.resp = r; e.b2b = 1'b0;
    exp_q.push_back(e);
    start = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 start = 1'b0; addr = 8'($urandom); wdata = 8'($urandom);
  endtask

  task automatic run_div2();
    longint      t0, last, cs_low;
    int          r2 = 0, n = 0;
    bit          sp_ok = 1, got_done = 0;
    logic [15:0] sh = '0;
    logic [7:0]  rd = '0;
    logic        pc = 1'b0, pcs = 1'b0;
    last = 0; cs_low = 0;
    @(negedge clk);
    start2 = 1'b1; addr2 = 8'hFF; wdata2 = 8'h00;
    @(posedge clk);
    #1 start2 = 1'b0; addr2 = 8'h5A; wdata2 = 8'h5A;
    t0 = cyc;
    while (!got_done && n < 200) begin
      @(negedge clk); n++;
      if (!pc && spi_clk2) begin
        if (r2 > 0 && (cyc - last) != 4) sp_ok = 0;
        last = cyc; r2++;
      end
      if (pc && !spi_clk2) sh = {sh[14:0], spi_mosi2};
      if (!pcs && spi_cs2) cs_low = cyc - t0;
      if (done2) begin got_done = 1; rd = rdata2; end
      pc = spi_clk2; pcs = spi_cs2;
    end
    check("div2_done_seen", got_done, 1);
    check("div2_rdata", rd, 8'hFF);
    check("div2_rises", r2, 16);
    check("div2_rise_spacing", sp_ok, 1);
    check("div2_cs_low", 32'(cs_low), 66);
    check("div2_mosi", sh, 16'hFF00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    longint      t;
    int          n;
    exp_t        e;
    logic [15:0] r;

    repeat (3) @(negedge clk);
    check("rst_cs", spi_cs, 1);
    check("rst_clk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;

    // write + readback
    issue(8'h07, 8'h35, 16'h00A5);

    // busy rejection: second start mid-frame must be ignored
    issue(8'h07, 8'h12, 16'($urandom));
    t = cyc;
    repeat (49) @(posedge clk);
    #1 start = 1'b1; addr = 8'h0B; wdata = 8'h99;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin @(negedge clk); n++; end
    check("busy_fall_cycle", 32'(cyc - t), 136);

    // back-to-back with start held; second frame takes the later inputs
    wait_idle();
    e.frame = 16'h2143; e.resp = 16'($urandom); e.b2b = 1'b0; exp_q.push_back(e);
    e.frame = 16'h5AC3; e.resp = 16'($urandom); e.b2b = 1'b1; exp_q.push_back(e);
    start = 1'b1; addr = 8'h21; wdata = 8'h43;
    @(posedge clk);
    #1 addr = 8'h5A; wdata = 8'hC3;
    repeat (34 * DIV) @(posedge clk);
    #1 start = 1'b0; addr = 8'($urandom); wdata = 8'($urandom);

    // randomized frames
    for (int i = 0; i < 6; i++) begin
      issue(8'($urandom), 8'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    r = 16'($urandom) | 16'h0001;
    issue(8'($urandom), 8'($urandom), r);

    // reset after rise 9
    issue(8'($urandom), 8'($urandom), 16'($urandom));
    repeat (2) @(negedge clk);
    n = 0;
    while (rises < 10 && n < 300) begin @(negedge clk); n++; end
    check("rise9_reached", (rises >= 10), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs", spi_cs, 1);
    check("abort_clk", spi_clk, 0);
    check("abort_busy", busy, 0);
    check("abort_rdata", rdata, 0);
    check("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(8'($urandom), 8'($urandom), 16'($urandom));
    wait_idle();

    run_div2();

    wait_idle();
    repeat (5) @(negedge clk);
    check("frames_outstanding", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
